// File: rtl/phase_sequencer.sv
// ---------------------------------------------------------------------------
// phase_sequencer
//
// Produces the execution phase (1..PHASE_LAST, 0 = stopped) for the control
// decoder. It also takes run/pause and single-step requests from the board
// push-buttons, honours the decoder's halt flag, and counts retired
// instructions for the debug display.
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active-high
//   exec_btn     run/pause button level (debounced, synchronous to clk)
//   step_btn     single-step button level (debounced, synchronous to clk)
//   hlt          halt flag from the control decoder, meaningful at phase 2
//   phase        current phase; 0 = idle or halted
//   running      high while an instruction is in progress (phase != 0)
//   halted       sticky halt indicator; only rst clears it
//   pause_pend   a pause is queued for the end of the current instruction
//   instr_done   one-cycle pulse during the cycle where phase == PHASE_LAST
//   instr_count  retired-instruction counter; wraps to 0 on overflow
//   fsm_state    sequencer state (0 IDLE, 1 RUN, 2 STEP, 3 HALT), for debug
//
// Handshake: there is no valid/ready traffic here. Each button produces one
// request on the cycle its level rises. The sequencer acts on that request
// in the same cycle or drops it, depending on the current state.
// ---------------------------------------------------------------------------
module phase_sequencer #(
  parameter int PHASE_LAST = 5,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exec_btn,
  input  logic             step_btn,
  input  logic             hlt,
  output logic [2:0]       phase,
  output logic             running,
  output logic             halted,
  output logic             pause_pend,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_count,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_HALT = 2'd3
  } state_t;

  localparam logic [2:0] P_LAST = 3'(PHASE_LAST);
  localparam logic [2:0] P_PRE  = 3'(PHASE_LAST - 1);
  localparam logic [2:0] P_HLT  = 3'd2;

  state_t state;
  logic   exec_q;
  logic   step_q;
  logic   exec_pulse;
  logic   step_pulse;
  logic   pause_eff;

  // One pulse per press: the level is high now and was low last cycle.
  // An exec press in the final phase still counts toward this instruction's
  // pause decision, so the decision uses the pending flag with this
  // cycle's toggle already applied.
  always_comb begin
    exec_pulse = exec_btn & ~exec_q;
    step_pulse = step_btn & ~step_q;
    pause_eff  = pause_pend ^ exec_pulse;
  end

  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      phase       <= 3'd0;
      running     <= 1'b0;
      halted      <= 1'b0;
      pause_pend  <= 1'b0;
      instr_done  <= 1'b0;
      instr_count <= '0;
      exec_q      <= 1'b0;
      step_q      <= 1'b0;
    end else begin
      exec_q     <= exec_btn;
      step_q     <= step_btn;
      instr_done <= 1'b0;

      case (state)
        S_IDLE: begin
          // If both buttons are pressed in the same cycle, exec wins.
          if (exec_pulse) begin
            state   <= S_RUN;
            phase   <= 3'd1;
            running <= 1'b1;
          end else if (step_pulse) begin
            state   <= S_STEP;
            phase   <= 3'd1;
            running <= 1'b1;
          end
        end

        S_RUN, S_STEP: begin
          if (phase == P_HLT && hlt) begin
            // Halt wins over a pending pause. The halting instruction does
            // not retire, so the counter and instr_done stay untouched.
            state      <= S_HALT;
            phase      <= 3'd0;
            running    <= 1'b0;
            halted     <= 1'b1;
            pause_pend <= 1'b0;
          end else if (phase == P_LAST) begin
            instr_count <= instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
            if (state == S_STEP || pause_eff) begin
              state      <= S_IDLE;
              phase      <= 3'd0;
              running    <= 1'b0;
              pause_pend <= 1'b0;
            end else begin
              // Next instruction starts back-to-back, with no idle cycle.
              phase      <= 3'd1;
              pause_pend <= 1'b0;
            end
          end else begin
            phase   <= phase + 3'd1;
            running <= 1'b1;
            // instr_done is registered, so it is raised one edge early to
            // line up with the cycle where phase shows PHASE_LAST.
            if (phase == P_PRE) instr_done <= 1'b1;
            if (state == S_RUN) pause_pend <= pause_eff;
          end
        end

        default: begin
          // S_HALT: button presses are dropped; only rst leaves this state.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
module tb_phase_sequencer;

  localparam int PL = 5;
  localparam int CW = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STEP = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;

  // ---------------- clock / reset / DUT ----------------
  logic          clk;
  logic          rst;
  logic          exec_btn;
  logic          step_btn;
  logic          hlt;
  logic [2:0]    phase;
  logic          running;
  logic          halted;
  logic          pause_pend;
  logic          instr_done;
  logic [CW-1:0] instr_count;
  logic [1:0]    fsm_state;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  phase_sequencer #(.PHASE_LAST(PL), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .exec_btn   (exec_btn),
    .step_btn   (step_btn),
    .hlt        (hlt),
    .phase      (phase),
    .running    (running),
    .halted     (halted),
    .pause_pend (pause_pend),
    .instr_done (instr_done),
    .instr_count(instr_count),
    .fsm_state  (fsm_state)
  );

  // ---------------- scoreboard ----------------
  localparam int OW = 3 + 1 + 1 + 1 + 1 + CW + 2;

  typedef struct {
    logic          r, e, s, h;
    logic [2:0]    ph;
    logic          ru, hl, pp, dn;
    logic [CW-1:0] cn;
    logic [1:0]    st;
  } vec_t;

  vec_t            tbl[$];
  logic [OW-1:0]   exp_q[$];
  int              n_checks = 0;
  int              n_errors = 0;

  function automatic logic [OW-1:0] pack(input logic [2:0] ph, input logic ru,
      input logic hl, input logic pp, input logic dn, input logic [CW-1:0] cn,
      input logic [1:0] st);
    return {ph, ru, hl, pp, dn, cn, st};
  endfunction

  task automatic add(input logic r, input logic e, input logic s, input logic h,
      input logic [2:0] ph, input logic ru, input logic hl, input logic pp,
      input logic dn, input logic [CW-1:0] cn, input logic [1:0] st);
    vec_t v;
    v.r = r; v.e = e; v.s = s; v.h = h;
    v.ph = ph; v.ru = ru; v.hl = hl; v.pp = pp; v.dn = dn; v.cn = cn; v.st = st;
    tbl.push_back(v);
  endtask

  // Compares the outputs against the oldest expected entry.
  task automatic check(input string name);
    logic [OW-1:0] got;
    logic [OW-1:0] exp;
    got = {phase, running, halted, pause_pend, instr_done, instr_count, fsm_state};
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got ph=%0d run=%0b hlt=%0b pp=%0b done=%0b cnt=%0d st=%0d, expected ph=%0d run=%0b hlt=%0b pp=%0b done=%0b cnt=%0d st=%0d",
        name, got[OW-1 -: 3], got[OW-4], got[OW-5], got[OW-6], got[OW-7],
        got[CW+1:2], got[1:0], exp[OW-1 -: 3], exp[OW-4], exp[OW-5],
        exp[OW-6], exp[OW-7], exp[CW+1:2], exp[1:0]);
    end
  endtask

  // ---------------- driver ----------------
  task automatic cyc(input logic r, input logic e, input logic s, input logic h);
    rst = r; exec_btn = e; step_btn = s; hlt = h;
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; exec_btn = 1'b0; step_btn = 1'b0; hlt = 1'b0;

    //   r e s h   ph ru hl pp dn cn st
    add(1,0,0,0,  0, 0, 0, 0, 0, 0, ST_IDLE);   // reset
    // exec held for 10 cycles: one RUN entry, back-to-back instructions
    add(0,1,0,0,  1, 1, 0, 0, 0, 0, ST_RUN);
    add(0,1,0,0,  2, 1, 0, 0, 0, 0, ST_RUN);
    add(0,1,0,0,  3, 1, 0, 0, 0, 0, ST_RUN);
    add(0,1,0,0,  4, 1, 0, 0, 0, 0, ST_RUN);
    add(0,1,0,0,  5, 1, 0, 0, 1, 0, ST_RUN);
    add(0,1,0,0,  1, 1, 0, 0, 0, 1, ST_RUN);
    add(0,1,0,0,  2, 1, 0, 0, 0, 1, ST_RUN);
    add(0,1,0,0,  3, 1, 0, 0, 0, 1, ST_RUN);
    add(0,1,0,0,  4, 1, 0, 0, 0, 1, ST_RUN);
    add(0,1,0,0,  5, 1, 0, 0, 1, 1, ST_RUN);
    add(0,0,0,0,  1, 1, 0, 0, 0, 2, ST_RUN);
    add(0,0,0,0,  2, 1, 0, 0, 0, 2, ST_RUN);
    add(0,0,0,0,  3, 1, 0, 0, 0, 2, ST_RUN);
    // exec at phase 3 -> pause at end of instruction
    add(0,1,0,0,  4, 1, 0, 1, 0, 2, ST_RUN);
    add(0,0,0,0,  5, 1, 0, 1, 1, 2, ST_RUN);
    add(0,0,0,0,  0, 0, 0, 0, 0, 3, ST_IDLE);
    // restart, pause at phase 2, cancel at phase 4
    add(0,1,0,0,  1, 1, 0, 0, 0, 3, ST_RUN);
    add(0,0,0,0,  2, 1, 0, 0, 0, 3, ST_RUN);
    add(0,1,0,0,  3, 1, 0, 1, 0, 3, ST_RUN);
    add(0,0,0,0,  4, 1, 0, 1, 0, 3, ST_RUN);
    add(0,1,0,0,  5, 1, 0, 0, 1, 3, ST_RUN);
    add(0,0,0,0,  1, 1, 0, 0, 0, 4, ST_RUN);
    add(0,0,0,0,  2, 1, 0, 0, 0, 4, ST_RUN);
    add(0,1,0,0,  3, 1, 0, 1, 0, 4, ST_RUN);
    add(0,0,0,0,  4, 1, 0, 1, 0, 4, ST_RUN);
    add(0,0,0,0,  5, 1, 0, 1, 1, 4, ST_RUN);
    add(0,0,0,0,  0, 0, 0, 0, 0, 5, ST_IDLE);
    // single step; exec and step presses inside STEP are dropped
    add(0,0,1,0,  1, 1, 0, 0, 0, 5, ST_STEP);
    add(0,0,1,0,  2, 1, 0, 0, 0, 5, ST_STEP);
    add(0,0,0,0,  3, 1, 0, 0, 0, 5, ST_STEP);
    add(0,1,0,0,  4, 1, 0, 0, 0, 5, ST_STEP);
    add(0,0,1,0,  5, 1, 0, 0, 1, 5, ST_STEP);
    add(0,0,0,0,  0, 0, 0, 0, 0, 6, ST_IDLE);
    add(0,0,0,0,  0, 0, 0, 0, 0, 6, ST_IDLE);
    // exec+step together -> RUN; hlt outside phase 2 is ignored
    add(0,1,1,0,  1, 1, 0, 0, 0, 6, ST_RUN);
    add(0,0,0,1,  2, 1, 0, 0, 0, 6, ST_RUN);
    add(0,0,0,0,  3, 1, 0, 0, 0, 6, ST_RUN);
    add(0,0,0,1,  4, 1, 0, 0, 0, 6, ST_RUN);
    add(0,0,0,1,  5, 1, 0, 0, 1, 6, ST_RUN);
    add(0,0,0,1,  1, 1, 0, 0, 0, 7, ST_RUN);
    add(0,0,0,0,  2, 1, 0, 0, 0, 7, ST_RUN);
    add(0,0,0,0,  3, 1, 0, 0, 0, 7, ST_RUN);
    add(0,0,1,0,  4, 1, 0, 0, 0, 7, ST_RUN);    // step in RUN ignored
    add(0,0,0,0,  5, 1, 0, 0, 1, 7, ST_RUN);
    add(0,0,0,0,  1, 1, 0, 0, 0, 8, ST_RUN);
    // reset mid-instruction, then halt at phase 2 of 4th instruction
    add(1,0,0,0,  0, 0, 0, 0, 0, 0, ST_IDLE);
    add(0,1,0,0,  1, 1, 0, 0, 0, 0, ST_RUN);
    add(0,0,0,0,  2, 1, 0, 0, 0, 0, ST_RUN);
    add(0,0,0,0,  3, 1, 0, 0, 0, 0, ST_RUN);
    add(0,0,0,0,  4, 1, 0, 0, 0, 0, ST_RUN);
    add(0,0,0,0,  5, 1, 0, 0, 1, 0, ST_RUN);
    add(0,0,0,0,  1, 1, 0, 0, 0, 1, ST_RUN);
    add(0,0,0,0,  2, 1, 0, 0, 0, 1, ST_RUN);
    add(0,0,0,0,  3, 1, 0, 0, 0, 1, ST_RUN);
    add(0,0,0,0,  4, 1, 0, 0, 0, 1, ST_RUN);
    add(0,0,0,0,  5, 1, 0, 0, 1, 1, ST_RUN);
    add(0,0,0,0,  1, 1, 0, 0, 0, 2, ST_RUN);
    add(0,0,0,0,  2, 1, 0, 0, 0, 2, ST_RUN);
    add(0,0,0,0,  3, 1, 0, 0, 0, 2, ST_RUN);
    add(0,0,0,0,  4, 1, 0, 0, 0, 2, ST_RUN);
    add(0,0,0,0,  5, 1, 0, 0, 1, 2, ST_RUN);
    add(0,0,0,0,  1, 1, 0, 0, 0, 3, ST_RUN);
    add(0,1,0,0,  2, 1, 0, 1, 0, 3, ST_RUN);    // pause pending
    add(0,0,0,1,  0, 0, 1, 0, 0, 3, ST_HALT);   // halt beats pause
    add(0,1,0,0,  0, 0, 1, 0, 0, 3, ST_HALT);
    add(0,0,1,0,  0, 0, 1, 0, 0, 3, ST_HALT);
    add(0,0,0,0,  0, 0, 1, 0, 0, 3, ST_HALT);
    add(1,0,0,0,  0, 0, 0, 0, 0, 0, ST_IDLE);

    foreach (tbl[i]) begin
      exp_q.push_back(pack(tbl[i].ph, tbl[i].ru, tbl[i].hl, tbl[i].pp,
                           tbl[i].dn, tbl[i].cn, tbl[i].st));
      cyc(tbl[i].r, tbl[i].e, tbl[i].s, tbl[i].h);
      check($sformatf("vec%0d", i));
    end

    // Counter wrap: 16 retirements on a 4-bit counter return it to 0.
    for (int i = 0; i < 16; i++) begin
      for (int k = 1; k <= PL; k++) begin
        if (i == 0 && k == 1) cyc(0, 1, 0, 0);
        else                  cyc(0, 0, 0, 0);
        exp_q.push_back(pack(3'(k), 1'b1, 1'b0, 1'b0, (k == PL),
                             CW'(i), ST_RUN));
        check($sformatf("wrap_i%0d_p%0d", i, k));
      end
    end
    cyc(0, 0, 0, 0);
    exp_q.push_back(pack(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, '0, ST_RUN));
    check("wrap_to_zero");
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    exp_q.push_back(pack(3'd3, 1'b1, 1'b0, 1'b0, 1'b0, '0, ST_RUN));
    check("before_rst_p3");

    // Reset at phase 3: everything back to reset values next cycle.
    cyc(1, 0, 0, 0);
    exp_q.push_back(pack(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, '0, ST_IDLE));
    check("rst_at_p3");
    cyc(0, 0, 0, 0);
    exp_q.push_back(pack(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, '0, ST_IDLE));
    check("idle_after_rst");

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
